// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
// Output bundle of the UART receiver: the single-entry valid/ready byte
// register plus the one-cycle error pulses.
//   rx_data     8  received byte
//   rx_valid    1  rx_data holds an unconsumed byte
//   rx_ready    1  consumer accepts rx_data when rx_valid && rx_ready
//   frame_err   1  pulse: stop bit sampled low
//   parity_err  1  pulse: parity mismatch (always 0 without parity support)
//   overrun     1  pulse: byte dropped because the holding register was full
// master = receiver side, slave = consumer side.
`timescale 1ns/1ps
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 16x oversampling UART receiver. Synchronises rx, deframes 8N1 characters
// (8E1 when the UART_RX_PARITY_EN macro is defined) and holds each byte in a
// single-entry valid/ready register. Errors are reported as one-cycle pulses.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   rx     in   serial line, idles high, asynchronous to clk
//   rx_if  master modport of uart_rx_core_if (rx_data, rx_valid, rx_ready,
//          frame_err, parity_err, overrun)
// Parameters: CLK_FREQ (Hz), BAUD (bit/s). Oversample divider is
// CLK_FREQ/(BAUD*16), truncated.
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    uart_rx_core_if.master   rx_if
);
    localparam int OVS_DIV = CLK_FREQ / (BAUD * 16);
    localparam int CNT_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q;
    logic               rx_meta_q;
    logic               rxs_q;
    logic               rxs_prev_q;
    logic [CNT_W-1:0]   tick_cnt_q;
    logic [3:0]         sc_q;
    logic [2:0]         bit_idx_q;
    logic               samp7_q;
    logic               samp8_q;
    logic [7:0]         shift_q;
    logic [7:0]         rx_data_q;
    logic               rx_valid_q;
    logic               frame_err_q;
    logic               overrun_q;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q;
    logic               parity_err_q;
`endif

    logic tick;
    logic fall;
    logic maj;

    assign tick = (tick_cnt_q == CNT_W'(OVS_DIV - 1));
    assign fall = rxs_prev_q & ~rxs_q;
    // Majority vote of the samples taken at sc = 7, 8 and the live one at sc = 9.
    assign maj  = (samp7_q & samp8_q) | (samp7_q & rxs_q) | (samp8_q & rxs_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            tick_cnt_q   <= '0;
            sc_q         <= 4'd0;
            bit_idx_q    <= 3'd0;
            samp7_q      <= 1'b1;
            samp8_q      <= 1'b1;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Consumption; a byte completing this same cycle overrides below.
            if (rx_valid_q && rx_if.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    tick_cnt_q <= '0;
                    if (fall) begin
                        state_q   <= S_START;
                        sc_q      <= 4'd0;
                        bit_idx_q <= 3'd0;
                    end
                end
                S_BREAK: begin
                    tick_cnt_q <= '0;
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
                    if (tick) begin
                        sc_q <= sc_q + 4'd1;
                        if (sc_q == 4'd7) samp7_q <= rxs_q;
                        if (sc_q == 4'd8) samp8_q <= rxs_q;
                        if (sc_q == 4'd9) begin
                            case (state_q)
                                S_START: state_q <= maj ? S_IDLE : S_DATA;
                                S_DATA: begin
                                    shift_q   <= {maj, shift_q[7:1]};
                                    bit_idx_q <= bit_idx_q + 3'd1;
                                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                        state_q <= S_PARITY;
`else
                                        state_q <= S_STOP;
`endif
                                    end
                                end
`ifdef UART_RX_PARITY_EN
                                S_PARITY: begin
                                    // Even parity: data bits plus parity bit XOR to 0.
                                    par_bad_q <= maj ^ (^shift_q);
                                    state_q   <= S_STOP;
                                end
`endif
                                S_STOP: begin
                                    if (maj) begin
                                        state_q <= S_IDLE;
                                        if (!rx_valid_q || rx_if.rx_ready) begin
                                            rx_data_q  <= shift_q;
                                            rx_valid_q <= 1'b1;
                                        end else begin
                                            overrun_q <= 1'b1;
                                        end
`ifdef UART_RX_PARITY_EN
                                        parity_err_q <= par_bad_q;
`endif
                                    end else begin
                                        frame_err_q <= 1'b1;
                                        state_q     <= S_BREAK;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Drives uart_rx_core at 115200 baud (27 clk per oversample tick, 432 clk per
// bit) from a bit-level line model. Each sent frame schedules its outcome at
// the frame start cycle plus the fixed receive latency; a per-cycle compare
// process applies the output register rules to that schedule and checks every
// DUT output. Directed tests add literal expectations on data, latency and
// pulse counts. Honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int BITC     = 432;          // 16 * 27 clk per bit
`ifdef UART_RX_PARITY_EN
    localparam int LAT      = 4593;         // 3 + (10*16 + 10) * 27
`else
    localparam int LAT      = 4161;         // 3 + (9*16 + 10) * 27
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_core_if bus();

    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rx_if (bus.master)
    );

    always #10 clk = ~clk;

    typedef struct {
        int         t;
        bit         good;
        logic [7:0] d;
        bit         perr;
    } ev_t;

    ev_t  evq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic ready_seen = 1'b0;
    int   n_rise = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter and the rx_ready value the DUT sees at each edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        ready_seen = bus.rx_ready;
    end

    // Per-cycle reference: output register behaviour driven by the schedule.
    initial begin
        logic       m_valid;
        logic [7:0] m_data;
        logic       ef, ep, eo, prev_v, cons;
        ev_t        e;
        m_valid = 1'b0;
        m_data  = 8'h00;
        prev_v  = 1'b0;
        forever begin
            @(negedge clk);
            ef = 1'b0; ep = 1'b0; eo = 1'b0;
            if (rst) begin
                m_valid = 1'b0;
                m_data  = 8'h00;
            end else begin
                cons = m_valid && ready_seen;
                if (evq.size() > 0 && evq[0].t < cyc) begin
                    e = evq.pop_front();
                    chk("event_missed", 32'(cyc), 32'(e.t));
                end
                if (evq.size() > 0 && evq[0].t == cyc) begin
                    e = evq.pop_front();
                    if (e.good) begin
                        if (!m_valid || ready_seen) begin
                            m_data  = e.d;
                            m_valid = 1'b1;
                        end else begin
                            eo = 1'b1;
                        end
                        ep = e.perr;
                    end else begin
                        ef = 1'b1;
                        if (cons) m_valid = 1'b0;
                    end
                end else if (cons) begin
                    m_valid = 1'b0;
                end
            end
            chk("rx_valid",   32'(bus.rx_valid),   32'(m_valid));
            chk("rx_data",    32'(bus.rx_data),    32'(m_data));
            chk("frame_err",  32'(bus.frame_err),  32'(ef));
            chk("parity_err", 32'(bus.parity_err), 32'(ep));
            chk("overrun",    32'(bus.overrun),    32'(eo));
            if (bus.rx_valid && !prev_v) n_rise++;
            prev_v = bus.rx_valid;
            if (bus.frame_err)  n_ferr++;
            if (bus.parity_err) n_perr++;
            if (bus.overrun)    n_ovr++;
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit stop_ok, input bit flip);
        ev_t e;
        e.t = cyc + LAT;
        e.good = stop_ok;
        e.d = d;
        e.perr = flip;
        evq.push_back(e);
        drive(1'b0, BITC);
        for (int i = 0; i < 8; i++) drive(d[i], BITC);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ flip, BITC);
`endif
        drive(stop_ok, BITC);
    endtask

    task automatic wait_valid(input string name, output int at, output logic [7:0] d);
        at = -1;
        d  = 8'hxx;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (bus.rx_valid) begin
                at = cyc;
                d  = bus.rx_data;
                break;
            end
        end
        if (at < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int         t0, tv, r0, f0, p0, o0;
        logic [7:0] dv;
        logic [7:0] b99;
        b99 = 8'h99;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data",  32'(bus.rx_data),  32'h00);
        chk("reset_valid", 32'(bus.rx_valid), 32'h0);
        #3 rst = 1'b0;
        @(negedge clk);
        repeat (50) @(negedge clk);

        // Single byte with the consumer always ready.
        bus.rx_ready = 1'b1;
        r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
        t0 = cyc;
        fork
            send(8'h55, 1'b1, 1'b0);
            wait_valid("single", tv, dv);
        join
        chk("single_data", 32'(dv), 32'h55);
        chk("single_latency", 32'(tv - t0), 32'(LAT));
        chk("single_rises", 32'(n_rise - r0), 32'd1);
        chk("single_errs", 32'(n_ferr - f0 + n_ovr - o0), 32'd0);

        // Back-to-back frames, each consumed once valid.
        bus.rx_ready = 1'b0;
        drive(1'b1, 100);
        fork
            begin
                send(8'hA3, 1'b1, 1'b0);
                send(8'h0F, 1'b1, 1'b0);
            end
            begin
                wait_valid("b2b_first", tv, dv);
                chk("b2b_first_data", 32'(dv), 32'hA3);
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
                wait_valid("b2b_second", tv, dv);
                chk("b2b_second_data", 32'(dv), 32'h0F);
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
            end
        join

        // Overrun: two bytes, never read.
        drive(1'b1, 100);
        o0 = n_ovr;
        send(8'h12, 1'b1, 1'b0);
        send(8'h34, 1'b1, 1'b0);
        chk("ovr_count", 32'(n_ovr - o0), 32'd1);
        chk("ovr_data", 32'(bus.rx_data), 32'h12);
        chk("ovr_valid", 32'(bus.rx_valid), 32'h1);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;

        // False start: 200 ns glitch.
        drive(1'b1, 100);
        r0 = n_rise; f0 = n_ferr;
        drive(1'b0, 10);
        drive(1'b1, BITC);
        chk("glitch_rises", 32'(n_rise - r0), 32'd0);
        chk("glitch_ferr", 32'(n_ferr - f0), 32'd0);

        // Framing error, line held low two more bits, then a good byte.
        bus.rx_ready = 1'b1;
        r0 = n_rise; f0 = n_ferr;
        send(8'hC6, 1'b0, 1'b0);
        drive(1'b0, 2 * BITC);
        drive(1'b1, BITC);
        chk("ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("ferr_rises", 32'(n_rise - r0), 32'd0);
        fork
            send(8'h7E, 1'b1, 1'b0);
            wait_valid("after_ferr", tv, dv);
        join
        chk("after_ferr_data", 32'(dv), 32'h7E);

        // Reset in the middle of bit 4 of 0x99.
        drive(1'b1, 100);
        drive(1'b0, BITC);
        for (int i = 0; i < 4; i++) drive(b99[i], BITC);
        drive(b99[4], BITC / 2);
        #3 rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk("rst_data",  32'(bus.rx_data),   32'h00);
        chk("rst_valid", 32'(bus.rx_valid),  32'h0);
        chk("rst_pulses", 32'({bus.frame_err, bus.parity_err, bus.overrun}), 32'h0);
        repeat (4) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 100);
        r0 = n_rise;
        fork
            send(8'h3C, 1'b1, 1'b0);
            wait_valid("after_rst", tv, dv);
        join
        chk("after_rst_data", 32'(dv), 32'h3C);
        chk("after_rst_rises", 32'(n_rise - r0), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: byte still delivered, parity_err with rx_valid.
        drive(1'b1, 100);
        p0 = n_perr;
        fork
            send(8'h3C, 1'b1, 1'b1);
            wait_valid("parity", tv, dv);
        join
        chk("parity_data", 32'(dv), 32'h3C);
        chk("parity_count", 32'(n_perr - p0), 32'd1);
`else
        p0 = 0;
        chk("parity_never", 32'(n_perr - p0), 32'd0);
`endif

        drive(1'b1, 50);
        chk("events_pending", 32'(evq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Asynchronous serial receiver for the UART test design. It runs on the 50 MHz system clock and generates its own 16x oversampling tick internally. It synchronises and samples the `rx` line, deframes 8N1 characters (8E1 when parity is compiled in), and presents each byte on a single-entry valid/ready output register. Error pulses report framing, parity and overrun conditions. It is the receive end of the link whose transmit side is driven by the project's baud divider and transmitter.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `OVS_DIV` (localparam), `CLK_FREQ/(BAUD*16)` using integer truncation, clocks per oversample tick. The default is 325.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `rx_ready`  in  1  consumer accepts `rx_data` when this and `rx_valid` are both high.
- `rx_data`  out  8  received byte, LSB first on the wire.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied to 0 when parity is not compiled in.
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was full and not being read.

## Operation
- **Input synchronisation:** `rx` passes through a 2-FF synchroniser with a reset value of 1. All logic below uses the synchronised signal `rxs`.
- **Tick generator:** counter `0..OVS_DIV-1`. It is held at 0 in IDLE and emits `tick` when it wraps.
- **Sample counter:** `sc` is 4 bits, wraps 15→0 and advances on `tick`. Bit value is the majority of `rxs` at `sc` = 7, 8 and 9. The bit is evaluated at `sc`=9.
- **State machine:** states IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling edge on `rxs` goes to START, clearing the tick counter, `sc`, and the bit index.
  - START: at evaluation, a majority of 1 is a false start and returns to IDLE. A majority of 0 goes to DATA.
  - DATA: evaluates 8 bits, shifting into bit 7 of the shift register (LSB received first). After bit 7 it goes to PARITY if parity is compiled in, otherwise to STOP.
  - PARITY: the received bit is compared against even parity of the data, then the FSM goes to STOP.
  - STOP: a majority of 1 means the byte is good and the FSM goes to IDLE. A majority of 0 pulses `frame_err`, discards the byte, and goes to BREAK.
  - BREAK: waits for `rxs`=1, then goes to IDLE.
- **Output register:** a good byte loads `rx_data` and sets `rx_valid`. `rx_valid` clears on the clock where `rx_valid && rx_ready`.
- **Overrun:** if a good byte completes while `rx_valid`=1 and `rx_ready`=0, the new byte is dropped, `rx_data` is unchanged, and `overrun` pulses.
- **Simultaneous completion and read:** if a good byte completes in the same cycle that `rx_valid && rx_ready`, the new byte loads and `rx_valid` stays 1. No overrun is reported.
- **Parity error:** on a parity error the byte is still delivered if the stop bit is good. `parity_err` pulses on the same cycle `rx_valid` rises, or would rise.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, FSM=IDLE, synchroniser=11.
- **Reset mid-frame:** the frame is abandoned immediately. After release, the first byte is received only after a fresh falling edge seen in IDLE.
- **Edge detection latency:** 2 clk (synchroniser) plus 1 clk (edge register) from the `rx` edge.
- **Bit period:** 16·`OVS_DIV` clk. Evaluation point is 9.5 ticks into each bit.
- **`rx_valid` rise (8N1):** on the clk after the STOP evaluation tick. This is (9·16+10)·`OVS_DIV`+3 clk after the start edge on `rx`, i.e. 50053 clk at the defaults. Add 16·`OVS_DIV` when parity is compiled in.
- **Error pulses:** `frame_err`, `parity_err` and `overrun` are exactly one clk wide and registered.
- **Back-to-back frames:** the FSM returns to IDLE roughly 6.5 ticks before the nominal end of the stop bit, so it accepts a start edge immediately following. Sender tolerance is about ±3% of the bit rate.

## Configuration
- **`UART_RX_PARITY_EN` defined:** frame is 8E1. The PARITY state exists, and `parity_err` is driven.
- **`UART_RX_PARITY_EN` undefined:** frame is 8N1. The PARITY state and its logic are removed, and `parity_err` is tied to 0.

## Test plan
Bench uses `BAUD`=115200, so `OVS_DIV`=27 and one bit is 432 clk (20 ns clock). A 115200-baud model drives `rx`.
- **Single byte:** send 0x55 with `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=0x55; no error pulses.
- **Back-to-back reads:** send 0xA3 then 0x0F with no idle gap, `rx_ready`=0 until each valid → `rx_data` 0xA3, then 0x0F after consume.
- **Overrun:** send 0x12 and 0x34 with `rx_ready` held 0 → `overrun` pulses once; `rx_data` stays 0x12 with `rx_valid`=1.
- **False start:** 200 ns low glitch on `rx` → no `rx_valid` and no errors; FSM back in IDLE within 1 bit period.
- **Framing error:** send 0xC6 with stop bit 0, `rx` low 2 further bits, then high → `frame_err` pulses once and no `rx_valid`. A following 0x7E is received correctly.
- **Reset and parity:** assert `rst` mid-bit-4 of 0x99 → all outputs 0, and the next 0x3C is received correctly. With `UART_RX_PARITY_EN`, 0x3C with parity bit 1 → `parity_err` pulse coincident with `rx_valid`.
